riscv_trace_buffer: RTL and testbench

- Synthesizable instruction-retirement trace buffer for the sequential RISC-V core. It moves the per-instruction state dump currently done by the simulation bench into hardware, so the same data is available on silicon.
- Sits beside the top level and snoops the commit point. Per retired instruction it records PC, instruction, destination register, RegWrite, writeback data and a serial number.
- Supports a PC-match start trigger and two buffer modes. Captured entries are drained through a valid/ready readout port.

---
 rtl/riscv_trace_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_riscv_trace_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_trace_buffer.sv
// Instruction-retirement trace buffer for the sequential RISC-V core.
// Snoops the commit point and records one entry per retired instruction
// (PC, instruction word, rd, RegWrite, writeback data, serial number).
// A session is started by arm, can wait for a PC trigger, and ends by halt
// or, in stop-on-full mode, by filling the buffer. Entries are drained
// oldest-first through a valid/ready port once the session is DONE.
module riscv_trace_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 16,
  parameter int MODE  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     commit_valid,
  input  logic [XLEN-1:0]          commit_pc,
  input  logic [31:0]              commit_instr,
  input  logic [4:0]               commit_rd,
  input  logic                     commit_we,
  input  logic [XLEN-1:0]          commit_wdata,
  input  logic                     arm,
  input  logic                     halt,
  input  logic                     trig_en,
  input  logic [XLEN-1:0]          trig_pc,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [XLEN-1:0]          rd_pc,
  output logic [31:0]              rd_instr,
  output logic [4:0]               rd_rd,
  output logic                     rd_we,
  output logic [XLEN-1:0]          rd_wdata,
  output logic [31:0]              rd_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ALMOST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_CAPT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     seq_q, seq_d;
  logic            overflow_q, overflow_d;
  logic            wr_en_s;

  // Entry storage; contents are only ever observed after being written.
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [4:0]      rd_mem    [DEPTH];
  logic            we_mem    [DEPTH];
  logic [XLEN-1:0] wdata_mem [DEPTH];
  logic [31:0]     seq_mem   [DEPTH];

  // Next-state logic: arm overrides everything, then per-state behaviour.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    overflow_d = overflow_q;
    wr_en_s    = 1'b0;
    if (arm) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      seq_d      = 32'd0;
      overflow_d = 1'b0;
      state_d    = trig_en ? ST_WAIT : ST_CAPT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_WAIT: begin
          if (halt) begin
            // Session ended before the trigger fired: nothing captured.
            state_d = ST_DONE;
            count_d = '0;
          end else if (commit_valid) begin
            seq_d = seq_q + 32'd1;
            if (commit_pc == trig_pc) begin
              wr_en_s  = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_ONE;
              count_d  = count_q + CNT_ONE;
              state_d  = ST_CAPT;
            end else begin
              state_d = ST_WAIT;
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_CAPT: begin
          if (commit_valid && !(MODE == 1 && count_q == CNT_FULL)) begin
            seq_d    = seq_q + 32'd1;
            wr_en_s  = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (count_q == CNT_FULL) begin
              // Wrap mode: newest entry replaces the oldest one.
              rd_ptr_d   = rd_ptr_q + PTR_ONE;
              overflow_d = 1'b1;
            end else begin
              count_d = count_q + CNT_ONE;
            end
            if (MODE == 1 && count_q == CNT_ALMOST) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_CAPT;
            end
          end else begin
            state_d = ST_CAPT;
          end
          if (halt) begin
            state_d = ST_DONE;
          end else begin
            state_d = state_d;
          end
        end
        ST_DONE: begin
          if (rd_valid && rd_ready) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_q - CNT_ONE;
          end else begin
            count_d = count_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= 32'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry write port; the stored serial number is the pre-increment value.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      pc_mem[wr_ptr_q]    <= commit_pc;
      instr_mem[wr_ptr_q] <= commit_instr;
      rd_mem[wr_ptr_q]    <= commit_rd;
      we_mem[wr_ptr_q]    <= commit_we;
      wdata_mem[wr_ptr_q] <= commit_wdata;
      seq_mem[wr_ptr_q]   <= seq_q;
    end
  end

  // Readout presents the oldest entry; fields read as zero when not valid.
  always_comb begin
    rd_valid = (state_q == ST_DONE) && (count_q != '0);
    if (rd_valid) begin
      rd_pc    = pc_mem[rd_ptr_q];
      rd_instr = instr_mem[rd_ptr_q];
      rd_rd    = rd_mem[rd_ptr_q];
      rd_we    = we_mem[rd_ptr_q];
      rd_wdata = wdata_mem[rd_ptr_q];
      rd_seq   = seq_mem[rd_ptr_q];
    end else begin
      rd_pc    = '0;
      rd_instr = 32'd0;
      rd_rd    = 5'd0;
      rd_we    = 1'b0;
      rd_wdata = '0;
      rd_seq   = 32'd0;
    end
  end

  assign count    = count_q;
  assign state    = state_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Scoreboard bench: one wrap-mode and one stop-on-full instance (DEPTH=4)
// share the commit stimulus; expected entries are queued per instance and a
// monitor compares each popped readout entry against the queue head.
module tb_riscv_trace_buffer;

  localparam int XLEN = 64;
  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] wdata;
    logic [31:0] seq;
  } entry_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic commit_valid = 1'b0;
  logic [63:0] commit_pc = 64'd0;
  logic [31:0] commit_instr = 32'd0;
  logic [4:0] commit_rd = 5'd0;
  logic commit_we = 1'b0;
  logic [63:0] commit_wdata = 64'd0;
  logic arm = 1'b0, halt = 1'b0, trig_en = 1'b0, rd_ready = 1'b0;
  logic [63:0] trig_pc = 64'd0;

  logic u0_rd_valid, u1_rd_valid, u0_rd_we, u1_rd_we, u0_ovf, u1_ovf;
  logic [63:0] u0_rd_pc, u1_rd_pc, u0_rd_wdata, u1_rd_wdata;
  logic [31:0] u0_rd_instr, u1_rd_instr, u0_rd_seq, u1_rd_seq;
  logic [4:0] u0_rd_rd, u1_rd_rd;
  logic [2:0] u0_count, u1_count;
  logic [1:0] u0_state, u1_state;

  entry_t q0[$];
  entry_t q1[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_instr(commit_instr), .commit_rd(commit_rd), .commit_we(commit_we),
    .commit_wdata(commit_wdata), .arm(arm), .halt(halt), .trig_en(trig_en),
    .trig_pc(trig_pc), .rd_ready(rd_ready), .rd_valid(u0_rd_valid), .rd_pc(u0_rd_pc),
    .rd_instr(u0_rd_instr), .rd_rd(u0_rd_rd), .rd_we(u0_rd_we), .rd_wdata(u0_rd_wdata),
    .rd_seq(u0_rd_seq), .count(u0_count), .state(u0_state), .overflow(u0_ovf));

  riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_instr(commit_instr), .commit_rd(commit_rd), .commit_we(commit_we),
    .commit_wdata(commit_wdata), .arm(arm), .halt(halt), .trig_en(trig_en),
    .trig_pc(trig_pc), .rd_ready(rd_ready), .rd_valid(u1_rd_valid), .rd_pc(u1_rd_pc),
    .rd_instr(u1_rd_instr), .rd_rd(u1_rd_rd), .rd_we(u1_rd_we), .rd_wdata(u1_rd_wdata),
    .rd_seq(u1_rd_seq), .count(u1_count), .state(u1_state), .overflow(u1_ovf));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic entry_t mk(input logic [63:0] pc, input logic [31:0] seq, input logic we);
    entry_t e;
    e.pc = pc;
    e.instr = pc[31:0] ^ 32'hA5A5_0013;
    e.rd = pc[6:2];
    e.we = we;
    e.wdata = pc * 64'd2;
    e.seq = seq;
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one commit for a cycle; returns the entry the bench expects for it.
  task automatic do_commit(input logic [63:0] pc, input logic [31:0] seq,
                           input logic we, output entry_t e);
    e = mk(pc, seq, we);
    commit_valid = 1'b1;
    commit_pc = e.pc;
    commit_instr = e.instr;
    commit_rd = e.rd;
    commit_we = e.we;
    commit_wdata = e.wdata;
    cyc();
    commit_valid = 1'b0;
  endtask

  task automatic pulse_arm(input logic te);
    trig_en = te;
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic pulse_halt();
    halt = 1'b1;
    cyc();
    halt = 1'b0;
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) cyc();
    rd_ready = 1'b0;
    chk("u0 rd_valid after drain", {63'd0, u0_rd_valid}, 64'd0);
    chk("u1 rd_valid after drain", {63'd0, u1_rd_valid}, 64'd0);
    chk("u0 count after drain", {61'd0, u0_count}, 64'd0);
    chk("u1 count after drain", {61'd0, u1_count}, 64'd0);
    chk("u0 entries left unread", q0.size(), 64'd0);
    chk("u1 entries left unread", q1.size(), 64'd0);
  endtask

  // Monitor: compare every accepted readout entry against the scoreboard.
  always @(negedge clk) begin
    if (reset && rd_ready && u0_rd_valid) begin
      if (q0.size() == 0) begin
        chk("u0 pop with empty scoreboard", q0.size(), 64'd1);
      end else begin
        chk("u0 rd_pc", u0_rd_pc, q0[0].pc);
        chk("u0 rd_seq", {32'd0, u0_rd_seq}, {32'd0, q0[0].seq});
        chk("u0 rd_wdata", u0_rd_wdata, q0[0].wdata);
        chk("u0 rd_instr", {32'd0, u0_rd_instr}, {32'd0, q0[0].instr});
        chk("u0 rd_rd/we", {58'd0, u0_rd_rd, u0_rd_we}, {58'd0, q0[0].rd, q0[0].we});
        void'(q0.pop_front());
      end
    end
    if (reset && rd_ready && u1_rd_valid) begin
      if (q1.size() == 0) begin
        chk("u1 pop with empty scoreboard", q1.size(), 64'd1);
      end else begin
        chk("u1 rd_pc", u1_rd_pc, q1[0].pc);
        chk("u1 rd_seq", {32'd0, u1_rd_seq}, {32'd0, q1[0].seq});
        chk("u1 rd_wdata", u1_rd_wdata, q1[0].wdata);
        chk("u1 rd_instr", {32'd0, u1_rd_instr}, {32'd0, q1[0].instr});
        chk("u1 rd_rd/we", {58'd0, u1_rd_rd, u1_rd_we}, {58'd0, q1[0].rd, q1[0].we});
        void'(q1.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    entry_t e;
    // Reset values.
    #12;
    chk("reset u0 state", {62'd0, u0_state}, 64'd0);
    chk("reset u1 count", {61'd0, u1_count}, 64'd0);
    chk("reset rd_valid/overflow", {60'd0, u0_rd_valid, u1_rd_valid, u0_ovf, u1_ovf}, 64'd0);
    chk("reset rd_pc", u0_rd_pc | u1_rd_pc, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc();

    // Stop-on-full (u1) and wrap (u0) with six commits, we=1, wdata=PC*2.
    pulse_arm(1'b0);
    chk("u0 state after arm", {62'd0, u0_state}, 64'd2);
    chk("u1 state after arm", {62'd0, u1_state}, 64'd2);
    for (int i = 0; i < 6; i++) begin
      do_commit(64'(4 * i), 32'(i), 1'b1, e);
      q0.push_back(e);
      if (i < 4) q1.push_back(e);
      if (i == 3) begin
        chk("u1 state DONE after 4th commit", {62'd0, u1_state}, 64'd3);
        chk("u1 count after 4th commit", {61'd0, u1_count}, 64'd4);
      end
    end
    while (q0.size() > DEPTH) void'(q0.pop_front());
    pulse_halt();
    chk("u0 state after halt", {62'd0, u0_state}, 64'd3);
    chk("u0 count full", {61'd0, u0_count}, 64'd4);
    chk("u0 overflow set", {63'd0, u0_ovf}, 64'd1);
    chk("u1 overflow clear", {63'd0, u1_ovf}, 64'd0);
    drain(6);

    // PC trigger at 0x10.
    trig_pc = 64'h10;
    pulse_arm(1'b1);
    chk("u1 WAIT_TRIG after arm", {62'd0, u1_state}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      do_commit(64'(4 * i), 32'(i), i[0], e);
      if (i >= 4) begin
        q0.push_back(e);
        q1.push_back(e);
      end
      if (i == 3) chk("u0 still WAIT_TRIG before match", {62'd0, u0_state}, 64'd1);
      if (i == 4) chk("u1 CAPTURE after match", {62'd0, u1_state}, 64'd2);
    end
    chk("u1 DONE after trigger fill", {62'd0, u1_state}, 64'd3);
    pulse_halt();
    chk("u0 overflow clear with trigger", {63'd0, u0_ovf}, 64'd0);
    drain(6);

    // Backpressure in DONE with two entries.
    trig_en = 1'b0;
    pulse_arm(1'b0);
    do_commit(64'h100, 32'd0, 1'b1, e);
    q0.push_back(e); q1.push_back(e);
    do_commit(64'h104, 32'd1, 1'b0, e);
    q0.push_back(e); q1.push_back(e);
    pulse_halt();
    for (int i = 0; i < 3; i++) begin
      chk("backpressure rd_pc held", u1_rd_pc, 64'h100);
      chk("backpressure rd_seq held", {32'd0, u0_rd_seq}, 64'd0);
      chk("backpressure count held", {61'd0, u0_count}, 64'd2);
      chk("backpressure rd_valid", {62'd0, u0_rd_valid, u1_rd_valid}, 64'd3);
      cyc();
    end
    drain(2);

    // arm together with commit and halt: arm wins, commit dropped.
    arm = 1'b1; halt = 1'b1;
    do_commit(64'h200, 32'd0, 1'b1, e);
    arm = 1'b0; halt = 1'b0;
    chk("priority u0 state CAPTURE", {62'd0, u0_state}, 64'd2);
    chk("priority u1 count 0", {61'd0, u1_count}, 64'd0);
    do_commit(64'h204, 32'd0, 1'b1, e);
    q0.push_back(e); q1.push_back(e);
    pulse_halt();
    drain(2);

    // Asynchronous reset mid-capture with three entries.
    pulse_arm(1'b0);
    for (int i = 0; i < 3; i++) do_commit(64'(8 * i), 32'(i), 1'b1, e);
    chk("count before reset", {61'd0, u0_count}, 64'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("async reset state", {60'd0, u0_state, u1_state}, 64'd0);
    chk("async reset count", {58'd0, u0_count, u1_count}, 64'd0);
    chk("async reset valid/ovf", {60'd0, u0_rd_valid, u1_rd_valid, u0_ovf, u1_ovf}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc();
    do_commit(64'h40, 32'd0, 1'b1, e);
    do_commit(64'h44, 32'd1, 1'b1, e);
    halt = 1'b1; cyc(); halt = 1'b0;
    chk("ignored after reset: state", {60'd0, u0_state, u1_state}, 64'd0);
    chk("ignored after reset: count", {58'd0, u0_count, u1_count}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
